muldiv_unit: RTL

- Parametrised multi-cycle multiply/divide unit implementing the RV32M operations; it is the sequential successor to the single-cycle combinational ALU.
- Sits beside the ALU in the execute stage. The datapath stalls on `busy` while an M-extension instruction is in flight.
- Radix-2 iterative datapath with a constant latency for all operations. The control FSM handles the start/done handshake, kill and the RISC-V special cases.

---
 rtl/muldiv_unit_if.sv | 23 ++
 rtl/muldiv_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multi-cycle multiply/divide unit.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  kill;
    logic [2:0]            Operation;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] Result;

    modport master (
        output start, kill, Operation, SrcA, SrcB,
        input  busy, done, Result
    );

    modport slave (
        input  start, kill, Operation, SrcA, SrcB,
        output busy, done, Result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Radix-2 iterative RV32M multiply/divide unit with constant DATA_WIDTH+1 cycle latency.
// Magnitudes are iterated unsigned; signs and RISC-V special cases are resolved in FIN.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
    logic [2:0]            op_reg, op_next;
    logic                  a_neg_reg, a_neg_next;
    logic                  b_neg_reg, b_neg_next;
    logic                  divzero_reg, divzero_next;
    logic                  ovf_reg, ovf_next;
    logic [DATA_WIDTH-1:0] src_a_reg, src_a_next;
    logic [DATA_WIDTH-1:0] a_mag_reg, a_mag_next;
    logic [DATA_WIDTH-1:0] b_mag_reg, b_mag_next;
    // acc_hi: product high half / partial remainder; acc_lo: product low half / quotient
    logic [DATA_WIDTH-1:0] acc_hi_reg, acc_hi_next;
    logic [DATA_WIDTH-1:0] acc_lo_reg, acc_lo_next;
    logic [DATA_WIDTH-1:0] result_reg, result_next;
    logic                  done_reg, done_next;
    logic                  busy_reg, busy_next;

    // Operand decode at accept time
    logic                  in_sign_a, in_sign_b;
    logic [DATA_WIDTH-1:0] in_mag_a, in_mag_b;
    logic                  in_is_div, in_signed_div;

    always_comb begin
        in_is_div     = bus.Operation[2];
        in_signed_div = (bus.Operation == OP_DIV) || (bus.Operation == OP_REM);
        in_sign_a     = bus.SrcA[DATA_WIDTH-1] &&
                        ((bus.Operation == OP_MULH) || (bus.Operation == OP_MULHSU) || in_signed_div);
        in_sign_b     = bus.SrcB[DATA_WIDTH-1] &&
                        ((bus.Operation == OP_MULH) || in_signed_div);
        in_mag_a      = in_sign_a ? (~bus.SrcA + 1'b1) : bus.SrcA;
        in_mag_b      = in_sign_b ? (~bus.SrcB + 1'b1) : bus.SrcB;
    end

    // One iteration step of each datapath
    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH:0]   div_shift;
    logic [DATA_WIDTH+1:0] div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, a_mag_reg} : '0);
        div_shift = {acc_hi_reg, acc_lo_reg[DATA_WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_mag_reg};
    end

    // Sign correction and result selection
    logic [2*DATA_WIDTH-1:0] prod_raw, prod_fix;
    logic [DATA_WIDTH-1:0]   quo_fix, rem_fix, fin_result;

    always_comb begin
        prod_raw = {acc_hi_reg, acc_lo_reg};
        prod_fix = (a_neg_reg ^ b_neg_reg) ? (~prod_raw + 1'b1) : prod_raw;
        quo_fix  = (a_neg_reg ^ b_neg_reg) ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
        rem_fix  = a_neg_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;
        fin_result = '0;
        case (op_reg)
            OP_MUL:                        fin_result = prod_fix[DATA_WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fin_result = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            OP_DIV, OP_DIVU: begin
                if (divzero_reg)
                    fin_result = '1;
                else if (ovf_reg)
                    fin_result = MIN_VAL;
                else
                    fin_result = quo_fix;
            end
            OP_REM, OP_REMU: begin
                if (divzero_reg)
                    fin_result = src_a_reg;
                else if (ovf_reg)
                    fin_result = '0;
                else
                    fin_result = rem_fix;
            end
            default:                       fin_result = '0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        op_next      = op_reg;
        a_neg_next   = a_neg_reg;
        b_neg_next   = b_neg_reg;
        divzero_next = divzero_reg;
        ovf_next     = ovf_reg;
        src_a_next   = src_a_reg;
        a_mag_next   = a_mag_reg;
        b_mag_next   = b_mag_reg;
        acc_hi_next  = acc_hi_reg;
        acc_lo_next  = acc_lo_reg;
        result_next  = result_reg;
        done_next    = 1'b0;
        busy_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.kill) begin
                    state_next   = CALC;
                    cnt_next     = '0;
                    op_next      = bus.Operation;
                    a_neg_next   = in_sign_a;
                    b_neg_next   = in_sign_b;
                    divzero_next = in_is_div && (bus.SrcB == '0);
                    ovf_next     = in_signed_div && (bus.SrcA == MIN_VAL) && (bus.SrcB == '1);
                    src_a_next   = bus.SrcA;
                    a_mag_next   = in_mag_a;
                    b_mag_next   = in_mag_b;
                    acc_hi_next  = '0;
                    acc_lo_next  = in_is_div ? in_mag_a : in_mag_b;
                end
            end
            CALC: begin
                if (bus.kill) begin
                    state_next = IDLE;
                end else begin
                    busy_next = 1'b1;
                    cnt_next  = cnt_reg + 1'b1;
                    if (op_reg[2]) begin
                        // Restoring step: keep the difference only when it did not go negative
                        if (!div_diff[DATA_WIDTH+1]) begin
                            acc_hi_next = div_diff[DATA_WIDTH-1:0];
                            acc_lo_next = {acc_lo_reg[DATA_WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi_next = div_shift[DATA_WIDTH-1:0];
                            acc_lo_next = {acc_lo_reg[DATA_WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi_next = mul_sum[DATA_WIDTH:1];
                        acc_lo_next = {mul_sum[0], acc_lo_reg[DATA_WIDTH-1:1]};
                    end
                    if (cnt_reg == LAST_CNT)
                        state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
                if (!bus.kill) begin
                    result_next = fin_result;
                    done_next   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            op_reg      <= '0;
            a_neg_reg   <= 1'b0;
            b_neg_reg   <= 1'b0;
            divzero_reg <= 1'b0;
            ovf_reg     <= 1'b0;
            src_a_reg   <= '0;
            a_mag_reg   <= '0;
            b_mag_reg   <= '0;
            acc_hi_reg  <= '0;
            acc_lo_reg  <= '0;
            result_reg  <= '0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            op_reg      <= op_next;
            a_neg_reg   <= a_neg_next;
            b_neg_reg   <= b_neg_next;
            divzero_reg <= divzero_next;
            ovf_reg     <= ovf_next;
            src_a_reg   <= src_a_next;
            a_mag_reg   <= a_mag_next;
            b_mag_reg   <= b_mag_next;
            acc_hi_reg  <= acc_hi_next;
            acc_lo_reg  <= acc_lo_next;
            result_reg  <= result_next;
            done_reg    <= done_next;
            busy_reg    <= busy_next;
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.Result = result_reg;

endmodule
